// File: rtl/age_matrix_issue_queue_pkg.sv
// Shared types and constants for the age-matrix issue queue.
//   PREGS / ROB_ENTRIES : core sizing that sets the tag and ROB index widths
//   IQ_NUM_CLASSES      : number of functional-unit classes
//   iq_uop_t            : micro-op as held in the queue and presented on issue
//   rob_younger()       : wrap-aware "strictly younger than" test against rob_head
package age_matrix_issue_queue_pkg;

  localparam int unsigned PREGS          = 64;
  localparam int unsigned ROB_ENTRIES    = 32;
  localparam int unsigned IQ_NUM_CLASSES = 4;

  localparam int unsigned IQ_TAG_W   = $clog2(PREGS);
  localparam int unsigned IQ_ROB_W   = $clog2(ROB_ENTRIES);
  localparam int unsigned IQ_CLASS_W = $clog2(IQ_NUM_CLASSES);

  typedef struct packed {
    logic [3:0]            opcode;
    logic [IQ_TAG_W-1:0]   src1_tag;
    logic [31:0]           src1_val;
    logic                  src1_ready;
    logic [IQ_TAG_W-1:0]   src2_tag;
    logic [31:0]           src2_val;
    logic                  src2_ready;
    logic [IQ_TAG_W-1:0]   dst_phys;
    logic [IQ_ROB_W-1:0]   dst_rob;
    logic [IQ_CLASS_W-1:0] fu_class;
  } iq_uop_t;

  // Distances are taken from rob_head so the comparison survives index wrap.
  function automatic logic rob_younger(input logic [IQ_ROB_W-1:0] rob,
                                       input logic [IQ_ROB_W-1:0] head,
                                       input logic [IQ_ROB_W-1:0] flush_idx);
    logic [IQ_ROB_W-1:0] d_entry;
    logic [IQ_ROB_W-1:0] d_flush;
    d_entry = rob - head;
    d_flush = flush_idx - head;
    return d_entry > d_flush;
  endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker for the issue-queue slots.
//   clk, reset : clock, asynchronous active-high reset (clears the matrix)
//   alloc_en   : slots written this cycle
//   alloc_row  : per-slot row loaded on allocation (bit j set = slot j is older)
//   free_en    : slots leaving this cycle; their columns are cleared
//   req        : candidate slots
//   oldest     : one-hot of the candidate with no older candidate
module iq_age_matrix
  import age_matrix_issue_queue_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ENTRIES-1:0]               alloc_en,
  input  logic [ENTRIES-1:0][ENTRIES-1:0]  alloc_row,
  input  logic [ENTRIES-1:0]               free_en,
  input  logic [ENTRIES-1:0]               req,
  output logic [ENTRIES-1:0]               oldest
);

  logic [ENTRIES-1:0] row_q [ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) row_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (alloc_en[i]) row_q[i] <= alloc_row[i] & ~free_en;
        else             row_q[i] <= row_q[i] & ~free_en;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int unsigned i = 0; i < ENTRIES; i++)
      oldest[i] = req[i] & ~(|(row_q[i] & req));
  end

endmodule

// File: rtl/age_matrix_issue_queue.sv
// Out-of-order issue queue with age-matrix oldest-first select per port.
//   clk, reset        : clock, asynchronous active-high reset
//   alloc_valid/ready : per-lane dispatch request, all-or-nothing grant
//   alloc_uop         : dispatched micro-ops
//   cdb_valid/tag/value : wakeup broadcast lanes
//   issue_valid/ready : per-port issue handshake
//   issue_uop         : selected micro-op with resolved operands
//   rob_head          : current ROB head for wrap-aware flush compare
//   flush_valid/flush_rob_idx : kill entries strictly younger than index
//   flush_all         : kill every entry
//   free_count, empty : registered occupancy
// Optional: define IQ_PERF_CNT_EN to add saturating perf counter ports
//   perf_alloc_stall, perf_issue_stall[NUM_PORTS], perf_empty_cycles.
module age_matrix_issue_queue
  import age_matrix_issue_queue_pkg::*;
#(
  parameter int unsigned ENTRIES     = 16,
  parameter int unsigned ALLOC_W     = 2,
  parameter int unsigned CDB_W       = 2,
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned NUM_CLASSES = IQ_NUM_CLASSES,
  parameter logic [NUM_PORTS*NUM_CLASSES-1:0] PORT_CLASS_MASK = {4'b0001, 4'b0001, 4'b0110},
  parameter int unsigned TAG_W       = IQ_TAG_W,
  parameter int unsigned ROB_W       = IQ_ROB_W,
  localparam int unsigned CNT_W      = $clog2(ENTRIES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ALLOC_W-1:0]              alloc_valid,
  output logic                            alloc_ready,
  input  iq_uop_t [ALLOC_W-1:0]           alloc_uop,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]     cdb_tag,
  input  logic [CDB_W-1:0][31:0]          cdb_value,
  output logic [NUM_PORTS-1:0]            issue_valid,
  input  logic [NUM_PORTS-1:0]            issue_ready,
  output iq_uop_t [NUM_PORTS-1:0]         issue_uop,
  input  logic [ROB_W-1:0]                rob_head,
  input  logic                            flush_valid,
  input  logic [ROB_W-1:0]                flush_rob_idx,
  input  logic                            flush_all,
  output logic [CNT_W-1:0]                free_count,
  output logic                            empty
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_alloc_stall,
  output logic [NUM_PORTS-1:0][31:0]      perf_issue_stall,
  output logic [31:0]                     perf_empty_cycles
`endif
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]  valid_q, valid_n;
  iq_uop_t             uop_q [ENTRIES];
  iq_uop_t             uop_n [ENTRIES];
  iq_uop_t             cap_uop [ALLOC_W];
  logic [CNT_W-1:0]    free_count_n, n_alloc, n_free;
  logic [NUM_PORTS-1:0] lock_q;
  logic [IDX_W-1:0]    lock_idx_q [NUM_PORTS];
  logic [IDX_W-1:0]    sel_idx [NUM_PORTS];

  logic                flush_cycle;
  logic [ENTRIES-1:0]  entry_ready, kill, issued, free_vec, alloc_slots, avail, all_locked;
  logic [ENTRIES-1:0][ENTRIES-1:0]   alloc_row;
  logic [NUM_PORTS-1:0][ENTRIES-1:0] lock_vec, grant;
  logic                found;

  // Lowest CDB lane wins when several lanes carry the same tag.
  function automatic iq_uop_t wake(input iq_uop_t u,
                                   input logic [CDB_W-1:0] v,
                                   input logic [CDB_W-1:0][TAG_W-1:0] t,
                                   input logic [CDB_W-1:0][31:0] d);
    iq_uop_t r;
    logic h1, h2;
    r  = u;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int unsigned c = 0; c < CDB_W; c++) begin
      if (v[c] && !u.src1_ready && !h1 && t[c] == u.src1_tag) begin
        h1 = 1'b1;
        r.src1_val = d[c];
      end
      if (v[c] && !u.src2_ready && !h2 && t[c] == u.src2_tag) begin
        h2 = 1'b1;
        r.src2_val = d[c];
      end
    end
    if (h1) r.src1_ready = 1'b1;
    if (h2) r.src2_ready = 1'b1;
    return r;
  endfunction

  assign flush_cycle = flush_valid | flush_all;
  assign alloc_ready = free_count >= CNT_W'(ALLOC_W);
  assign empty       = free_count == CNT_W'(ENTRIES);

  always_comb begin
    entry_ready = '0;
    kill        = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      entry_ready[i] = valid_q[i] & uop_q[i].src1_ready & uop_q[i].src2_ready;
      kill[i] = valid_q[i] & (flush_all |
                (flush_valid & rob_younger(uop_q[i].dst_rob, rob_head, flush_rob_idx)));
    end
  end

  // A port that stalled on an entry keeps it so issue_uop stays stable;
  // the lock lapses once the entry is gone (issued or killed).
  always_comb begin
    lock_vec   = '0;
    all_locked = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (lock_q[p] && valid_q[lock_idx_q[p]]) lock_vec[p][lock_idx_q[p]] = 1'b1;
      all_locked = all_locked | lock_vec[p];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_port
    localparam logic [NUM_CLASSES-1:0] PMASK = PORT_CLASS_MASK[p*NUM_CLASSES +: NUM_CLASSES];
    logic [ENTRIES-1:0] taken_in, taken_out, class_ok, req, oldest;

    if (p == 0) begin : gen_first
      assign taken_in = '0;
    end else begin : gen_rest
      assign taken_in = gen_port[p-1].taken_out;
    end

    always_comb begin
      class_ok = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) class_ok[i] = PMASK[uop_q[i].fu_class];
    end

    assign req = entry_ready & class_ok & ~taken_in & ~all_locked;

    iq_age_matrix #(.ENTRIES(ENTRIES)) u_age (
      .clk       (clk),
      .reset     (reset),
      .alloc_en  (alloc_slots),
      .alloc_row (alloc_row),
      .free_en   (free_vec),
      .req       (req),
      .oldest    (oldest)
    );

    assign grant[p]  = (|lock_vec[p]) ? lock_vec[p] : oldest;
    assign taken_out = taken_in | grant[p];
  end

  always_comb begin
    issue_valid = '0;
    issue_uop   = '0;
    issued      = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      sel_idx[p]     = '0;
      issue_valid[p] = |grant[p];
      if (issue_ready[p]) issued = issued | grant[p];
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (grant[p][i]) begin
          issue_uop[p] = uop_q[i];
          sel_idx[p]   = IDX_W'(i);
        end
      end
    end
  end

  assign free_vec = (issued | kill) & valid_q;

  always_comb begin
    for (int unsigned l = 0; l < ALLOC_W; l++) begin
      cap_uop[l] = alloc_uop[l];
      if (cap_uop[l].src1_tag == '0) cap_uop[l].src1_ready = 1'b1;
      if (cap_uop[l].src2_tag == '0) cap_uop[l].src2_ready = 1'b1;
      cap_uop[l] = wake(cap_uop[l], cdb_valid, cdb_tag, cdb_value);
    end
  end

  // Lanes claim the lowest free slots in lane order; each new row sees the
  // surviving valid entries plus slots claimed by earlier lanes.
  always_comb begin
    avail       = ~valid_q;
    alloc_slots = '0;
    alloc_row   = '0;
    n_alloc     = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++)
      uop_n[i] = valid_q[i] ? wake(uop_q[i], cdb_valid, cdb_tag, cdb_value) : uop_q[i];
    for (int unsigned l = 0; l < ALLOC_W; l++) begin
      if (alloc_valid[l] && alloc_ready && !flush_cycle) begin
        found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          if (!found && avail[i]) begin
            found          = 1'b1;
            avail[i]       = 1'b0;
            alloc_row[i]   = valid_q | alloc_slots;
            alloc_slots[i] = 1'b1;
            uop_n[i]       = cap_uop[l];
          end
        end
        n_alloc = n_alloc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    n_free = '0;
    for (int unsigned i = 0; i < ENTRIES; i++)
      if (free_vec[i]) n_free = n_free + CNT_W'(1);
    free_count_n = free_count + n_free - n_alloc;
    valid_n      = (valid_q & ~free_vec) | alloc_slots;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      free_count <= CNT_W'(ENTRIES);
      lock_q     <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) lock_idx_q[p] <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) uop_q[i] <= '0;
    end else begin
      valid_q    <= valid_n;
      free_count <= free_count_n;
      lock_q     <= issue_valid & ~issue_ready;
      for (int unsigned p = 0; p < NUM_PORTS; p++) lock_idx_q[p] <= sel_idx[p];
      for (int unsigned i = 0; i < ENTRIES; i++) uop_q[i] <= uop_n[i];
    end
  end

`ifdef IQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_alloc_stall  <= '0;
      perf_issue_stall  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if ((|alloc_valid) && !alloc_ready && perf_alloc_stall != '1)
        perf_alloc_stall <= perf_alloc_stall + 32'd1;
      for (int unsigned p = 0; p < NUM_PORTS; p++)
        if (issue_valid[p] && !issue_ready[p] && perf_issue_stall[p] != '1)
          perf_issue_stall[p] <= perf_issue_stall[p] + 32'd1;
      if (empty && perf_empty_cycles != '1)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_age_matrix_issue_queue.sv
module tb_age_matrix_issue_queue;
  import age_matrix_issue_queue_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        alloc_valid;
  logic              alloc_ready;
  iq_uop_t [1:0]     alloc_uop;
  logic [1:0]        cdb_valid;
  logic [1:0][5:0]   cdb_tag;
  logic [1:0][31:0]  cdb_value;
  logic [2:0]        issue_valid;
  logic [2:0]        issue_ready;
  iq_uop_t [2:0]     issue_uop;
  logic [4:0]        rob_head;
  logic              flush_valid;
  logic [4:0]        flush_rob_idx;
  logic              flush_all;
  logic [4:0]        free_count;
  logic              empty;

  int checks = 0;
  int errors = 0;

  // Ports 0 and 1 take class 0, port 2 takes classes 1 and 2; class 3 never issues.
  age_matrix_issue_queue #(
    .ENTRIES         (16),
    .ALLOC_W         (2),
    .CDB_W           (2),
    .NUM_PORTS       (3),
    .PORT_CLASS_MASK (12'b0110_0001_0001)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_uop     (alloc_uop),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_uop     (issue_uop),
    .rob_head      (rob_head),
    .flush_valid   (flush_valid),
    .flush_rob_idx (flush_rob_idx),
    .flush_all     (flush_all),
    .free_count    (free_count),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic iq_uop_t mk(input logic [3:0] op, input logic [5:0] t1, input logic r1,
                                 input logic [5:0] t2, input logic r2,
                                 input logic [4:0] rob, input logic [1:0] cls);
    iq_uop_t u;
    u            = '0;
    u.opcode     = op;
    u.src1_tag   = t1;
    u.src1_ready = r1;
    u.src1_val   = 32'h1000 + 32'(t1);
    u.src2_tag   = t2;
    u.src2_ready = r2;
    u.src2_val   = 32'h2000 + 32'(t2);
    u.dst_phys   = 6'(op) + 6'd10;
    u.dst_rob    = rob;
    u.fu_class   = cls;
    return u;
  endfunction

  task automatic idle();
    alloc_valid   = '0;
    alloc_uop     = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_value     = '0;
    issue_ready   = '0;
    flush_valid   = 1'b0;
    flush_rob_idx = '0;
    flush_all     = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rob_head = '0;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("rst_free", 64'(free_count), 64'd16);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_uop0", 64'(issue_uop[0].opcode), 64'd0);

    // Same-cycle CDB capture at allocation, then later wakeup.
    alloc_valid  = 2'b11;
    alloc_uop[0] = mk(4'd1, 6'd5, 1'b0, 6'd0, 1'b0, 5'd0, 2'd0);
    alloc_uop[1] = mk(4'd2, 6'd7, 1'b0, 6'd0, 1'b0, 5'd1, 2'd0);
    cdb_valid    = 2'b01;
    cdb_tag[0]   = 6'd5;
    cdb_value[0] = 32'hAA;
    tick();
    idle();
    cdb_valid    = 2'b01;
    cdb_tag[0]   = 6'd7;
    cdb_value[0] = 32'hBB;
    check("s1_valid_first", 64'(issue_valid), 64'b001);
    check("s1_src_capture", 64'(issue_uop[0].src1_val), 64'hAA);
    check("s1_free", 64'(free_count), 64'd14);
    tick();
    idle();
    check("s1_valid_both", 64'(issue_valid), 64'b011);
    check("s1_hold_op", 64'(issue_uop[0].opcode), 64'd1);
    check("s1_wake_val", 64'(issue_uop[1].src1_val), 64'hBB);
    issue_ready = 3'b011;
    tick();
    idle();
    check("s1_drained", 64'(free_count), 64'd16);
    check("s1_no_issue", 64'(issue_valid), 64'd0);

    // Two CDB lanes hit the same tag: lane 0 value is taken.
    alloc_valid  = 2'b01;
    alloc_uop[0] = mk(4'd5, 6'd9, 1'b0, 6'd3, 1'b1, 5'd2, 2'd0);
    tick();
    idle();
    check("dup_waiting", 64'(issue_valid), 64'd0);
    cdb_valid = 2'b11;
    cdb_tag[0] = 6'd9; cdb_value[0] = 32'h11;
    cdb_tag[1] = 6'd9; cdb_value[1] = 32'h22;
    tick();
    idle();
    check("dup_valid", 64'(issue_valid), 64'b001);
    check("dup_lane0", 64'(issue_uop[0].src1_val), 64'h11);
    issue_ready = 3'b001;
    tick();
    idle();
    check("dup_free", 64'(free_count), 64'd16);

    // Fill: one class-2 entry then class-3 pairs until one slot remains.
    alloc_valid  = 2'b01;
    alloc_uop[0] = mk(4'd9, 6'd3, 1'b1, 6'd4, 1'b1, 5'd3, 2'd2);
    tick();
    for (int k = 0; k < 7; k++) begin
      alloc_valid  = 2'b11;
      alloc_uop[0] = mk(4'd10, 6'd3, 1'b1, 6'd4, 1'b1, 5'(4 + 2*k), 2'd3);
      alloc_uop[1] = mk(4'd11, 6'd3, 1'b1, 6'd4, 1'b1, 5'(5 + 2*k), 2'd3);
      tick();
    end
    idle();
    check("fill_free1", 64'(free_count), 64'd1);
    check("fill_ready_low", 64'(alloc_ready), 64'd0);
    check("fill_port2", 64'(issue_valid), 64'b100);
    check("fill_port2_op", 64'(issue_uop[2].opcode), 64'd9);
    alloc_valid = 2'b11;
    tick();
    idle();
    check("fill_blocked", 64'(free_count), 64'd1);
    issue_ready = 3'b100;
    tick();
    idle();
    check("fill_free2", 64'(free_count), 64'd2);
    check("fill_ready_back", 64'(alloc_ready), 64'd1);
    flush_all    = 1'b1;
    alloc_valid  = 2'b11;
    alloc_uop[0] = mk(4'd12, 6'd3, 1'b1, 6'd4, 1'b1, 5'd0, 2'd0);
    alloc_uop[1] = mk(4'd13, 6'd3, 1'b1, 6'd4, 1'b1, 5'd1, 2'd0);
    tick();
    idle();
    check("fa_free", 64'(free_count), 64'd16);
    check("fa_empty", 64'(empty), 64'd1);
    check("fa_no_issue", 64'(issue_valid), 64'd0);

    // Oldest-first across ports with a stalled port holding its uop.
    alloc_valid  = 2'b11;
    alloc_uop[0] = mk(4'd1, 6'd3, 1'b1, 6'd4, 1'b1, 5'd4, 2'd0);
    alloc_uop[1] = mk(4'd2, 6'd3, 1'b1, 6'd4, 1'b1, 5'd5, 2'd0);
    tick();
    idle();
    alloc_valid  = 2'b01;
    alloc_uop[0] = mk(4'd3, 6'd3, 1'b1, 6'd4, 1'b1, 5'd6, 2'd0);
    tick();
    idle();
    check("age_valid", 64'(issue_valid), 64'b011);
    check("age_p0_A", 64'(issue_uop[0].opcode), 64'd1);
    check("age_p1_B", 64'(issue_uop[1].opcode), 64'd2);
    issue_ready = 3'b010;
    tick();
    idle();
    check("age_p0_held", 64'(issue_uop[0].opcode), 64'd1);
    check("age_p1_C", 64'(issue_uop[1].opcode), 64'd3);
    check("age_free", 64'(free_count), 64'd14);
    issue_ready = 3'b011;
    tick();
    idle();
    check("age_drained", 64'(free_count), 64'd16);

    // Partial flush across ROB index wrap.
    rob_head     = 5'd30;
    alloc_valid  = 2'b11;
    alloc_uop[0] = mk(4'd4, 6'd3, 1'b1, 6'd4, 1'b1, 5'd30, 2'd3);
    alloc_uop[1] = mk(4'd5, 6'd3, 1'b1, 6'd4, 1'b1, 5'd31, 2'd3);
    tick();
    alloc_uop[0] = mk(4'd6, 6'd3, 1'b1, 6'd4, 1'b1, 5'd0, 2'd3);
    alloc_uop[1] = mk(4'd7, 6'd3, 1'b1, 6'd4, 1'b1, 5'd1, 2'd3);
    tick();
    idle();
    check("fl_pre", 64'(free_count), 64'd12);
    flush_valid   = 1'b1;
    flush_rob_idx = 5'd31;
    tick();
    idle();
    check("fl_wrap_kill", 64'(free_count), 64'd14);
    flush_valid   = 1'b1;
    flush_rob_idx = 5'd30;
    tick();
    idle();
    check("fl_head_keep", 64'(free_count), 64'd15);
    flush_all = 1'b1;
    tick();
    idle();
    check("fl_all", 64'(free_count), 64'd16);
    rob_head = '0;

    // Asynchronous reset with five live entries.
    for (int k = 0; k < 3; k++) begin
      alloc_valid  = (k == 2) ? 2'b01 : 2'b11;
      alloc_uop[0] = mk(4'(k + 1), 6'd3, 1'b1, 6'd4, 1'b1, 5'(2*k), 2'd0);
      alloc_uop[1] = mk(4'(k + 8), 6'd3, 1'b1, 6'd4, 1'b1, 5'(2*k + 1), 2'd0);
      tick();
    end
    idle();
    check("ar_pre_free", 64'(free_count), 64'd11);
    check("ar_pre_issue", 64'(issue_valid), 64'b011);
    #2;
    reset = 1'b1;
    #1;
    check("ar_issue_valid", 64'(issue_valid), 64'd0);
    check("ar_free", 64'(free_count), 64'd16);
    check("ar_empty", 64'(empty), 64'd1);
    #1;
    reset = 1'b0;
    tick();
    check("ar_after", 64'(free_count), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
